// File: rtl/wb_regfile_if.sv
// Write-back stage bus: MEM/WB pipeline register outputs, ID read ports,
// forwarding value and retirement status.
//   master : pipeline / ID side (drives MEM/WB fields and read addresses)
//   slave  : wb_regfile (drives read data, wb_data, retire_count, last_pc)
interface wb_regfile_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  wb_valid;
  logic                  wb_stall;
  logic [ADDR_WIDTH-1:0] wb_pc;
  logic [DATA_WIDTH-1:0] wb_alu_result;
  logic [DATA_WIDTH-1:0] wb_mem_data;
  logic [2:0]            wb_funct3;
  logic [4:0]            wb_rd;
  logic                  wb_memtoreg;
  logic                  wb_regwrite;
  logic [4:0]            rs1_addr;
  logic [4:0]            rs2_addr;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [63:0]           retire_count;
  logic [ADDR_WIDTH-1:0] last_pc;

  modport master (
    output wb_valid, wb_stall, wb_pc, wb_alu_result, wb_mem_data, wb_funct3,
           wb_rd, wb_memtoreg, wb_regwrite, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_data, retire_count, last_pc
  );

  modport slave (
    input  wb_valid, wb_stall, wb_pc, wb_alu_result, wb_mem_data, wb_funct3,
           wb_rd, wb_memtoreg, wb_regwrite, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_data, retire_count, last_pc
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 integer register file.
// Selects ALU result or extended load data, commits it to the register file,
// serves two combinational read ports with same-cycle write-through bypass,
// and tracks a 64-bit retired-instruction count plus the last retired PC.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : wb_regfile_if.slave (MEM/WB inputs, read ports, wb_data, status)
module wb_regfile #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
  input  logic         clk,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  logic                  commit;
  logic                  we;
  logic [1:0]            off;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic [DATA_WIDTH-1:0] wb_data_d;

  logic [DATA_WIDTH-1:0] regs_q [1:31];
  logic [63:0]           retire_count_q;
  logic [ADDR_WIDTH-1:0] last_pc_q;

  // A stalled instruction is held in MEM/WB and commits on its first unstalled edge.
  assign commit = bus.wb_valid & ~bus.wb_stall;
  assign we     = commit & bus.wb_regwrite & (bus.wb_rd != 5'd0);
  assign off    = bus.wb_alu_result[1:0];

  always_comb begin
    ld_byte = bus.wb_mem_data[7:0];
    case (off)
      2'd0: ld_byte = bus.wb_mem_data[7:0];
      2'd1: ld_byte = bus.wb_mem_data[15:8];
      2'd2: ld_byte = bus.wb_mem_data[23:16];
      2'd3: ld_byte = bus.wb_mem_data[31:24];
      default: ld_byte = bus.wb_mem_data[7:0];
    endcase
    // Halfword select ignores off[0]; misaligned halves are not split.
    ld_half = off[1] ? bus.wb_mem_data[31:16] : bus.wb_mem_data[15:0];
    case (bus.wb_funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = bus.wb_mem_data;
    endcase
    wb_data_d = bus.wb_memtoreg ? ld_ext : bus.wb_alu_result;
  end

  assign bus.wb_data = wb_data_d;

  // x0 reads zero; a same-cycle write to the addressed register wins over the array.
  always_comb begin
    bus.rs1_data = '0;
    if (bus.rs1_addr == 5'd0)
      bus.rs1_data = '0;
    else if (we && (bus.rs1_addr == bus.wb_rd))
      bus.rs1_data = wb_data_d;
    else
      bus.rs1_data = regs_q[bus.rs1_addr];
  end

  always_comb begin
    bus.rs2_data = '0;
    if (bus.rs2_addr == 5'd0)
      bus.rs2_data = '0;
    else if (we && (bus.rs2_addr == bus.wb_rd))
      bus.rs2_data = wb_data_d;
    else
      bus.rs2_data = regs_q[bus.rs2_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < 32; i++)
        regs_q[i] <= '0;
    end else if (we) begin
      regs_q[bus.wb_rd] <= wb_data_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_count_q <= '0;
      last_pc_q      <= PC_ADDR;
    end else if (commit) begin
      retire_count_q <= retire_count_q + 64'd1;
      last_pc_q      <= bus.wb_pc;
    end
  end

  assign bus.retire_count = retire_count_q;
  assign bus.last_pc      = last_pc_q;

endmodule
